// File: rtl/and8_pkg.sv
// Shared constants for the AND lane of the 8-bit ALU.
package and8_pkg;

    localparam int AND8_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/and8_skid_buffer.sv
// Two-entry output buffer (main + skid) for a valid/ready stream.
// in_ready depends only on registered state, so out_ready never reaches it combinationally.
module skid_buffer #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] main_reg;
    logic [DW-1:0] skid_reg;
    logic          main_full_reg;
    logic          skid_full_reg;

    logic in_fire;
    logic out_fire;
    logic main_open;

    assign in_ready  = ~skid_full_reg & ~rst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_full_reg & out_ready;
    assign main_open = ~main_full_reg | out_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg      <= '0;
            skid_reg      <= '0;
            main_full_reg <= 1'b0;
            skid_full_reg <= 1'b0;
        end else if (main_open) begin
            if (skid_full_reg) begin
                // Older skid entry advances first so ordering is kept.
                main_reg      <= skid_reg;
                main_full_reg <= 1'b1;
                if (in_fire) begin
                    skid_reg <= in_data;
                end else begin
                    skid_full_reg <= 1'b0;
                end
            end else begin
                main_full_reg <= in_fire;
                if (in_fire) begin
                    main_reg <= in_data;
                end
            end
        end else if (in_fire) begin
            skid_reg      <= in_data;
            skid_full_reg <= 1'b1;
        end
    end

    assign out_valid = main_full_reg;
    assign out_data  = main_reg;

endmodule

// File: rtl/and8.sv
// AND lane of the ALU: z = a & b plus zero flag, returned through a skid buffer.
module and8
    import and8_pkg::*;
#(
    parameter int WIDTH = AND8_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero
);

    logic [WIDTH-1:0] and_res;
    logic             zero_res;
    logic [WIDTH:0]   buf_out;

    assign and_res  = a & b;
    assign zero_res = ~|and_res;

    skid_buffer #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({zero_res, and_res}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign z    = buf_out[WIDTH-1:0];
    assign zero = buf_out[WIDTH];

endmodule

// File: tb/tb_and8.sv
// Scoreboard bench for and8: driver pushes expected results, monitor pops on output transfers.
module tb_and8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] z;
    logic       zero;

    typedef struct {
        logic [7:0] ez;
        logic       ezero;
        int         cyc;
        logic       lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;

    and8 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok %s = %0h", nm, act);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                         input logic [7:0] ez, input logic ezero,
                         input logic ordy, input logic lat);
        exp_t e;
        in_valid  = v;
        a         = da;
        b         = db;
        out_ready = ordy;
        #1;
        if (v && in_ready) begin
            e.ez = ez; e.ezero = ezero; e.cyc = cyc; e.lat = lat;
            sb.push_back(e);
            acc_cnt++;
            $display("push a=%b b=%b exp z=%b zero=%b", da, db, ez, ezero);
        end
        @(negedge clk);
    endtask

    // Monitor: pops on every output transfer, and checks hold-stability under stall.
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_z;
        logic       prev_zero;
        exp_t       e;
        prev_stall = 1'b0;
        prev_z     = '0;
        prev_zero  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid) begin
                    chk("stall_hold_z", {24'd0, z}, {24'd0, prev_z});
                    chk("stall_hold_zero", {31'd0, zero}, {31'd0, prev_zero});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output z=%b with empty scoreboard", z);
                    end else begin
                        e = sb.pop_front();
                        chk("result_z", {24'd0, z}, {24'd0, e.ez});
                        chk("result_zero", {31'd0, zero}, {31'd0, e.ezero});
                        if (e.lat) chk("latency", cyc - e.cyc, 1);
                    end
                end
                prev_stall = out_valid & ~out_ready;
                prev_z     = z;
                prev_zero  = zero;
            end
        end
    end

    initial begin : stim
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rz;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_z", {24'd0, z}, 0);
        chk("reset_zero", {31'd0, zero}, 0);
        chk("reset_in_ready", {31'd0, in_ready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 1);
        @(negedge clk);

        // Streaming, one pair per cycle.
        drive(1, 8'b00010010, 8'b01000101, 8'b00000000, 1, 1, 1);
        drive(1, 8'b00010110, 8'b01010101, 8'b00010100, 0, 1, 1);
        drive(1, 8'b10010010, 8'b01000111, 8'b00000010, 0, 1, 1);
        drive(1, 8'b00010011, 8'b01000100, 8'b00000000, 1, 1, 1);
        drive(1, 8'b00011010, 8'b00000101, 8'b00000000, 1, 1, 1);
        drive(1, 8'b00110010, 8'b11000101, 8'b00000000, 1, 1, 1);
        drive(1, 8'b00010110, 8'b01000001, 8'b00000000, 1, 1, 1);
        drive(1, 8'b11111111, 8'b11111111, 8'b11111111, 0, 1, 1);
        drive(0, 8'hFF, 8'hFF, 8'h00, 0, 1, 0);
        drive(0, 8'h5A, 8'hA5, 8'h00, 0, 1, 0);

        // Backpressure: only two of three get in.
        acc_cnt = 0;
        drive(1, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
        drive(1, 8'h0F, 8'hFF, 8'h0F, 0, 0, 0);
        drive(1, 8'hAA, 8'h55, 8'h00, 1, 0, 0);
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_in_ready_low", {31'd0, in_ready}, 0);
        drive(0, 8'h11, 8'h22, 8'h00, 0, 0, 0);
        drive(0, 8'h33, 8'h44, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        #1;
        chk("bp_in_ready_rise", {31'd0, in_ready}, 1);
        drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);

        // Simultaneous input/output transfer around a full skid.
        drive(1, 8'hC3, 8'h81, 8'h81, 0, 0, 0);
        drive(1, 8'h7E, 8'h18, 8'h18, 0, 0, 0);
        drive(1, 8'h99, 8'h91, 8'h91, 0, 1, 0);
        drive(1, 8'h99, 8'h91, 8'h91, 0, 1, 0);
        drive(1, 8'h3C, 8'h0F, 8'h0C, 0, 1, 0);
        repeat (3) drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        chk("sim_drained", sb.size(), 0);

        // Asynchronous reset with the buffer full.
        drive(1, 8'hEE, 8'h77, 8'h66, 0, 0, 0);
        drive(1, 8'hDD, 8'hBB, 8'h99, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_z", {24'd0, z}, 0);
        chk("rst_zero", {31'd0, zero}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", {31'd0, in_ready}, 1);
        drive(1, 8'h6C, 8'h5A, 8'h48, 0, 1, 1);
        drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);

        // Random traffic against the a & b model.
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rz = ra & rb;
            drive(1'($urandom_range(0, 1)), ra, rb, rz, ~|rz,
                  1'($urandom_range(0, 3) != 0), 0);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            drive(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        end
        chk("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
